wb_cmd_master: RTL and testbench

Wishbone pipelined bus master that turns a simple valid/ready command port into single Wishbone read or write cycles and returns one response per command. It is the initiator for the generated register-bank slaves, for use in test harnesses and in small on-chip sequencers. It also handles slave retry and bus timeout, so a hung or absent slave never blocks the command port indefinitely.

---
 rtl/wb_cmd_master.sv | 168 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined master: turns a valid/ready command into single bus cycles,
// with slave retry back-off and a per-issue timeout so the command port never hangs.
module wb_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]            cmd_sel_i,
    input  logic [31:0]           cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i
);

    localparam int unsigned TCNT_W = 16;
    localparam int unsigned RCNT_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam logic [TCNT_W-1:0] TLIMIT = TCNT_W'(TIMEOUT - 1);
    localparam logic [RCNT_W-1:0] RLIMIT = RCNT_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_BACKOFF,
        S_RSP
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]          r_sel;
    logic [DATA_W-1:0]   r_dat;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_dat;
    logic                r_rsp_err;
    logic                r_rsp_timeout;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [RCNT_W-1:0]   r_rcnt;

    logic                w_err;
    logic                w_rty;
    logic                w_ack;
    logic                w_term;
    logic                w_tmo;
    logic                w_retry;

    // Slave terminations are only meaningful inside a cycle; priority err > rty > ack
    assign w_err   = r_cyc & wb_err_i;
    assign w_rty   = r_cyc & wb_rty_i & ~wb_err_i;
    assign w_ack   = r_cyc & wb_ack_i & ~wb_rty_i & ~wb_err_i;
    assign w_term  = w_err | w_rty | w_ack;
    assign w_tmo   = r_cyc & ~w_term & (r_tcnt == TLIMIT);
    assign w_retry = w_rty & (r_rcnt < RLIMIT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b0;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_sel         <= '0;
            r_dat         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_tcnt        <= '0;
            r_rcnt        <= '0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (cmd_valid_i && r_ready) begin
                        r_ready <= 1'b0;
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_sel   <= cmd_sel_i;
                        r_dat   <= cmd_dat_i;
                        r_tcnt  <= '0;
                        r_rcnt  <= '0;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (w_term || w_tmo) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        if (w_retry) begin
                            r_rcnt  <= r_rcnt + RCNT_W'(1);
                            r_state <= S_BACKOFF;
                        end else begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= w_err | w_rty;
                            r_rsp_timeout <= w_tmo;
                            r_rsp_dat     <= (w_ack && !r_we) ? wb_dat_i : '0;
                            r_state       <= S_RSP;
                        end
                    end else begin
                        if (r_tcnt != '1) begin
                            r_tcnt <= r_tcnt + TCNT_W'(1);
                        end
                        if (r_state == S_REQ && !wb_stall_i) begin
                            r_stb   <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_BACKOFF: begin
                    r_tcnt  <= '0;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_state <= S_REQ;
                end
                S_RSP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = r_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;
    assign wb_cyc_o      = r_cyc;
    assign wb_stb_o      = r_stb;
    assign wb_we_o       = r_we;
    assign wb_adr_o      = r_adr;
    assign wb_sel_o      = r_sel;
    assign wb_dat_o      = r_dat;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: scripted Wishbone slave plus an outcome model
// computed per command from the slave script.
module tb_wb_cmd_master;

    localparam int unsigned AW   = 32;
    localparam int          TMO  = 8;
    localparam int          RMAX = 3;
    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_NONE = 3, K_ACKERR = 4, K_ACKRTY = 5;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [3:0]    cmd_sel_i;
    logic [31:0]   cmd_dat_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_dat_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

    wb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .RETRY_MAX(RMAX)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Slave script, one entry per bus issue of the current command
    int          p_kind [8];
    int          p_delay[8];
    int          p_stall[8];
    logic [31:0] rd_data;
    logic        junk_en = 1'b0;

    // Observed behaviour of the last command
    int          o_wait, o_issues, o_stb, o_lat, o_rsp_cnt;
    int          o_gap_bad, o_stable_bad, o_flag_bad;
    int          o_len[8];
    logic [31:0] o_dat, o_post_dat;
    logic        o_err, o_tmo, o_post_ready;

    // Expected outcome of the last command
    int          e_issues, e_stb, e_lat;
    int          e_len[8];
    logic [31:0] e_dat;
    logic        e_err, e_tmo;

    function automatic void clear_plan();
        for (int k = 0; k < 8; k++) begin
            p_kind[k]  = K_NONE;
            p_delay[k] = 0;
            p_stall[k] = 0;
        end
    endfunction

    // Outcome derived from the slave script: issue lengths, strobes, latency, response
    function automatic void model_cmd(input logic we);
        int len;
        e_issues = 0; e_stb = 0; e_lat = 0;
        e_err = 1'b0; e_tmo = 1'b0; e_dat = 32'h0;
        for (int k = 0; k < 8; k++) e_len[k] = 0;
        for (int k = 0; k < 8; k++) begin
            e_issues++;
            if (p_kind[k] == K_NONE || p_delay[k] >= TMO) begin
                len   = TMO;
                e_tmo = 1'b1;
            end else begin
                len = p_delay[k] + 1;
            end
            e_len[k] = len;
            e_stb   += (p_stall[k] + 1 < len) ? p_stall[k] + 1 : len;
            e_lat   += len;
            if (e_tmo) break;
            if (p_kind[k] == K_ERR || p_kind[k] == K_ACKERR) begin
                e_err = 1'b1;
                break;
            end
            if (p_kind[k] == K_RTY || p_kind[k] == K_ACKRTY) begin
                if (k < RMAX) begin
                    e_lat += 1;
                    continue;
                end
                e_err = 1'b1;
                break;
            end
            e_dat = we ? 32'h0 : rd_data;
            break;
        end
    endfunction

    // Issues one command, plays the slave script and records what the DUT did
    task automatic do_cmd(input logic we, input logic [AW-1:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat);
        int   k, kk, cyc_idx, gap;
        logic prev_cyc, hit;
        o_issues = 0; o_stb = 0; o_lat = -1; o_rsp_cnt = 0;
        o_gap_bad = 0; o_stable_bad = 0; o_flag_bad = 0;
        o_err = 1'b0; o_tmo = 1'b0; o_dat = 32'h0; o_post_dat = 32'h0; o_post_ready = 1'b0;
        for (int i = 0; i < 8; i++) o_len[i] = 0;
        o_wait = 0;
        while (cmd_ready_o !== 1'b1 && o_wait < 50) begin
            @(negedge clk_i);
            o_wait++;
        end
        if (cmd_ready_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL cmd_ready wait: got %b required 1 within 50 cycles", cmd_ready_o);
            return;
        end
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
        @(negedge clk_i);
        cmd_valid_i = 1'b0; cmd_we_i = 1'($urandom_range(0, 1));
        cmd_adr_i = $urandom; cmd_sel_i = 4'($urandom); cmd_dat_i = $urandom;
        prev_cyc = 1'b0; k = -1; cyc_idx = 0; gap = 0;
        for (int t = 0; t < 200; t++) begin
            if (wb_cyc_o === 1'b1) begin
                if (!prev_cyc) begin
                    k++; o_issues++; cyc_idx = 0;
                    if (k > 0 && gap != 1) o_gap_bad++;
                end
                kk = (k < 8) ? k : 7;
                o_len[kk]++;
                if (wb_stb_o === 1'b1) o_stb++;
                if (wb_adr_o !== adr || wb_sel_o !== sel || wb_we_o !== we || wb_dat_o !== dat)
                    o_stable_bad++;
                hit        = (cyc_idx == p_delay[kk]);
                wb_stall_i = (cyc_idx < p_stall[kk]);
                wb_ack_i   = hit && (p_kind[kk] == K_ACK || p_kind[kk] == K_ACKERR || p_kind[kk] == K_ACKRTY);
                wb_err_i   = hit && (p_kind[kk] == K_ERR || p_kind[kk] == K_ACKERR);
                wb_rty_i   = hit && (p_kind[kk] == K_RTY || p_kind[kk] == K_ACKRTY);
                wb_dat_i   = wb_ack_i ? rd_data : $urandom;
                cyc_idx++;
                gap = 0;
            end else begin
                gap++;
                wb_stall_i = 1'($urandom_range(0, 1));
                wb_ack_i   = junk_en & 1'($urandom_range(0, 1));
                wb_err_i   = junk_en & 1'($urandom_range(0, 1));
                wb_rty_i   = junk_en & 1'($urandom_range(0, 1));
                wb_dat_i   = $urandom;
            end
            prev_cyc = wb_cyc_o;
            if (rsp_valid_o === 1'b1) begin
                o_rsp_cnt++;
                if (o_lat < 0) begin
                    o_lat = t; o_dat = rsp_dat_o; o_err = rsp_err_o; o_tmo = rsp_timeout_o;
                end
            end else if (rsp_err_o !== 1'b0 || rsp_timeout_o !== 1'b0) begin
                o_flag_bad++;
            end
            if (o_lat >= 0 && t == o_lat + 1) begin
                o_post_ready = cmd_ready_o;
                o_post_dat   = rsp_dat_o;
                break;
            end
            @(negedge clk_i);
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #12;
        checks++;
        if ({cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o, wb_cyc_o, wb_stb_o,
             wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b cyc=%b stb=%b adr=%h required all 0",
                     cmd_ready_o, rsp_valid_o, wb_cyc_o, wb_stb_o, wb_adr_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: got %b required 0", cmd_ready_o);
        end
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_after_release: got %b required 1", cmd_ready_o);
        end
    endtask

    task automatic test_read_stall();
        clear_plan();
        p_kind[0] = K_ACK; p_delay[0] = 1; p_stall[0] = 1;
        rd_data = 32'hDEADBEEF;
        do_cmd(1'b0, 32'h4, 4'hF, 32'h0);
        checks++;
        if (o_rsp_cnt !== 1) begin errors++; $display("FAIL read_stall rsp_count: got %0d required 1", o_rsp_cnt); end
        checks++;
        if (o_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL read_stall data: got %h required deadbeef", o_dat); end
        checks++;
        if (o_err !== 1'b0 || o_tmo !== 1'b0) begin errors++; $display("FAIL read_stall flags: got err=%b tmo=%b required 0 0", o_err, o_tmo); end
        checks++;
        if (o_stb !== 2) begin errors++; $display("FAIL read_stall stb_cycles: got %0d required 2", o_stb); end
        checks++;
        if (o_lat !== 2) begin errors++; $display("FAIL read_stall latency: got %0d required 2", o_lat); end
    endtask

    task automatic test_write();
        clear_plan();
        p_kind[0] = K_ACK; p_delay[0] = 3;
        rd_data = 32'h12345678;
        do_cmd(1'b1, 32'h0, 4'hF, 32'h2);
        checks++;
        if (o_stable_bad !== 0) begin errors++; $display("FAIL write bus_stable: got %0d bad cycles required 0", o_stable_bad); end
        checks++;
        if (o_dat !== 32'h0 || o_err !== 1'b0) begin errors++; $display("FAIL write rsp: got dat=%h err=%b required 0 0", o_dat, o_err); end
        checks++;
        if (o_lat !== 4 || o_len[0] !== 4) begin errors++; $display("FAIL write timing: got lat=%0d len=%0d required 4 4", o_lat, o_len[0]); end
    endtask

    task automatic test_retry();
        clear_plan();
        for (int k = 0; k < 4; k++) begin p_kind[k] = K_RTY; p_delay[k] = k; end
        rd_data = $urandom;
        model_cmd(1'b0);
        do_cmd(1'b0, 32'h100, 4'h3, 32'h0);
        checks++;
        if (o_issues !== 4 || o_gap_bad !== 0) begin errors++; $display("FAIL retry_exhaust issues: got %0d gaps_bad=%0d required 4 0", o_issues, o_gap_bad); end
        checks++;
        if (o_err !== 1'b1 || o_tmo !== 1'b0 || o_dat !== 32'h0) begin errors++; $display("FAIL retry_exhaust rsp: got err=%b tmo=%b dat=%h required 1 0 0", o_err, o_tmo, o_dat); end
        checks++;
        if (o_lat !== e_lat) begin errors++; $display("FAIL retry_exhaust latency: got %0d required %0d", o_lat, e_lat); end
        p_kind[3] = K_ACK; p_delay[3] = 1;
        rd_data = 32'hCAFE0001;
        do_cmd(1'b0, 32'h104, 4'hF, 32'h0);
        checks++;
        if (o_issues !== 4 || o_err !== 1'b0 || o_dat !== 32'hCAFE0001) begin errors++; $display("FAIL retry_success: got issues=%0d err=%b dat=%h required 4 0 cafe0001", o_issues, o_err, o_dat); end
    endtask

    task automatic test_timeout();
        clear_plan();
        rd_data = $urandom;
        do_cmd(1'b0, 32'h200, 4'hF, 32'h0);
        checks++;
        if (o_len[0] !== TMO || o_issues !== 1) begin errors++; $display("FAIL timeout cyc_len: got %0d issues=%0d required %0d 1", o_len[0], o_issues, TMO); end
        checks++;
        if (o_tmo !== 1'b1 || o_err !== 1'b0 || o_rsp_cnt !== 1) begin errors++; $display("FAIL timeout rsp: got tmo=%b err=%b cnt=%0d required 1 0 1", o_tmo, o_err, o_rsp_cnt); end
        p_kind[0] = K_ACK; p_delay[0] = TMO - 1;
        rd_data = 32'h0BADF00D;
        do_cmd(1'b0, 32'h204, 4'hF, 32'h0);
        checks++;
        if (o_tmo !== 1'b0 || o_err !== 1'b0 || o_dat !== 32'h0BADF00D || o_len[0] !== TMO) begin
            errors++; $display("FAIL timeout_last_ack: got tmo=%b err=%b dat=%h len=%0d required 0 0 0badf00d %0d", o_tmo, o_err, o_dat, o_len[0], TMO);
        end
    endtask

    task automatic test_ack_err();
        clear_plan();
        p_kind[0] = K_ACKERR; p_delay[0] = 0;
        rd_data = 32'h55AA55AA;
        do_cmd(1'b0, 32'h300, 4'hF, 32'h0);
        checks++;
        if (o_err !== 1'b1 || o_dat !== 32'h0 || o_tmo !== 1'b0 || o_lat !== 1) begin
            errors++; $display("FAIL ack_err: got err=%b dat=%h tmo=%b lat=%0d required 1 0 0 1", o_err, o_dat, o_tmo, o_lat);
        end
    endtask

    task automatic test_reset_midcycle();
        int seen;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h400; cmd_sel_i = 4'hF; cmd_dat_i = 32'h0;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL midreset wait_state: got cyc=%b stb=%b required 1 0", wb_cyc_o, wb_stb_o); end
        #2 rst_n_i = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
            errors++; $display("FAIL midreset async_drop: got cyc=%b stb=%b ready=%b required 0 0 0", wb_cyc_o, wb_stb_o, cmd_ready_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL midreset after_release: got stray=%0d ready=%b required 0 1", seen, cmd_ready_o); end
        clear_plan();
        p_kind[0] = K_ACK; p_delay[0] = 2;
        rd_data = 32'hA5A50F0F;
        do_cmd(1'b0, 32'h404, 4'hF, 32'h0);
        checks++;
        if (o_rsp_cnt !== 1 || o_dat !== 32'hA5A50F0F || o_err !== 1'b0) begin
            errors++; $display("FAIL midreset next_read: got cnt=%0d dat=%h err=%b required 1 a5a50f0f 0", o_rsp_cnt, o_dat, o_err);
        end
    endtask

    task automatic test_back_to_back();
        clear_plan();
        p_kind[0] = K_ACK; p_delay[0] = 0;
        for (int n = 0; n < 3; n++) begin
            rd_data = $urandom;
            do_cmd(1'b0, 32'(32'h500 + 4 * n), 4'hF, 32'h0);
            checks++;
            if (o_lat !== 1 || o_dat !== rd_data || o_post_ready !== 1'b1 || (n > 0 && o_wait !== 0)) begin
                errors++; $display("FAIL back_to_back[%0d]: got lat=%0d dat=%h ready=%b wait=%0d required 1 %h 1 0", n, o_lat, o_dat, o_post_ready, o_wait, rd_data);
            end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        junk_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1)); adr = $urandom; sel = 4'($urandom); dat = $urandom;
            rd_data = $urandom;
            for (int k = 0; k < 8; k++) begin
                p_kind[k]  = int'($urandom_range(0, 5));
                p_delay[k] = int'($urandom_range(0, 9));
                p_stall[k] = int'($urandom_range(0, 3));
            end
            model_cmd(we);
            do_cmd(we, adr, sel, dat);
            checks++;
            if (o_rsp_cnt !== 1 || o_lat !== e_lat) begin errors++; $display("FAIL random[%0d] timing: got cnt=%0d lat=%0d required 1 %0d", n, o_rsp_cnt, o_lat, e_lat); end
            checks++;
            if (o_dat !== e_dat || o_err !== e_err || o_tmo !== e_tmo) begin
                errors++; $display("FAIL random[%0d] rsp: got dat=%h err=%b tmo=%b required %h %b %b", n, o_dat, o_err, o_tmo, e_dat, e_err, e_tmo);
            end
            checks++;
            if (o_issues !== e_issues || o_stb !== e_stb || o_len[0] !== e_len[0]) begin
                errors++; $display("FAIL random[%0d] bus: got issues=%0d stb=%0d len0=%0d required %0d %0d %0d", n, o_issues, o_stb, o_len[0], e_issues, e_stb, e_len[0]);
            end
            checks++;
            if (o_stable_bad !== 0 || o_gap_bad !== 0 || o_flag_bad !== 0) begin
                errors++; $display("FAIL random[%0d] protocol: got stable_bad=%0d gap_bad=%0d flag_bad=%0d required 0 0 0", n, o_stable_bad, o_gap_bad, o_flag_bad);
            end
            checks++;
            if (o_post_ready !== 1'b1 || o_post_dat !== e_dat) begin
                errors++; $display("FAIL random[%0d] post: got ready=%b dat=%h required 1 %h", n, o_post_ready, o_post_dat, e_dat);
            end
        end
        junk_en = 1'b0;
    endtask

    initial begin
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_sel_i = '0; cmd_dat_i = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
        rd_data = '0;
        clear_plan();
        test_reset();
        test_read_stall();
        test_write();
        test_retry();
        test_timeout();
        test_ack_err();
        test_reset_midcycle();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
